// File: rtl/sysid_check_if.sv
// sysid_check_if: Avalon-MM read-only link between the sysid checker and the sysid slave.
interface sysid_check_if;
    logic        address;
    logic        read;
    logic        waitrequest;
    logic [31:0] readdata;
    modport master (output address, read, input waitrequest, readdata);
    modport slave (input address, read, output waitrequest, readdata);
endinterface

// File: rtl/sysid_check.sv
// sysid_check: reads the sysid ID and timestamp words and compares them to expected values.
module sysid_check #(
    parameter logic [31:0] EXPECTED_ID    = 32'd590062172,
    parameter logic [31:0] EXPECTED_TS    = 32'd1328122208,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    sysid_check_if.master        avm,
    output logic                 busy,
    output logic                 done,
    output logic                 id_ok,
    output logic                 ts_ok,
    output logic                 timeout,
    output logic [31:0]          id_value,
    output logic [31:0]          ts_value
);
    localparam logic [15:0] TMAX = 16'(TIMEOUT_CYCLES);
    typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, FINISH} state_t;
    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic        id_ok_n, ts_ok_n, timeout_n;
    logic [31:0] id_value_n, ts_value_n;
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        id_ok_n    = id_ok;
        ts_ok_n    = ts_ok;
        timeout_n  = timeout;
        id_value_n = id_value;
        ts_value_n = ts_value;
        case (state)
            IDLE: if (start) begin
                state_n    = RD_ID;
                cnt_n      = '0;
                id_ok_n    = 1'b0;
                ts_ok_n    = 1'b0;
                timeout_n  = 1'b0;
                id_value_n = '0;
                ts_value_n = '0;
            end
            RD_ID, RD_TS: begin
                // acceptance wins over the limit, even when the counter sits at TMAX
                if (!avm.waitrequest) begin
                    cnt_n = '0;
                    if (state == RD_ID) begin
                        id_value_n = avm.readdata;
                        id_ok_n    = avm.readdata == EXPECTED_ID;
                        state_n    = RD_TS;
                    end else begin
                        ts_value_n = avm.readdata;
                        ts_ok_n    = avm.readdata == EXPECTED_TS;
                        state_n    = FINISH;
                    end
                end else if (cnt == TMAX) begin
                    timeout_n = 1'b1;
                    state_n   = FINISH;
                end else
                    cnt_n = cnt + 16'd1;
            end
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // bus and status outputs are registered copies of the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            avm.read    <= 1'b0;
            avm.address <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            avm.read    <= state_n == RD_ID || state_n == RD_TS;
            avm.address <= state_n == RD_TS;
            busy        <= state_n != IDLE;
            done        <= state_n == FINISH;
            id_ok       <= id_ok_n;
            ts_ok       <= ts_ok_n;
            timeout     <= timeout_n;
            id_value    <= id_value_n;
            ts_value    <= ts_value_n;
        end
    end
endmodule
